exu_shift_unit: RTL and testbench
=================================

# exu_shift_unit

Execute-stage wrapper that feeds the combinational `Shift` datapath. It accepts decoded RV32I shift operations (SLL/SRL/SRA and immediate forms) over a valid/ready handshake, decodes funct3/funct7 into shifter controls, and masks the shift amount. It buffers results in a 2-entry FIFO so writeback can apply backpressure without stalling the shifter combinationally.

## Interface
- `WIDTH`, default 32: datapath width; must be a power of two ≥ 8.
- `SHW`, default $clog2(WIDTH): shift-amount width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous pipeline flush; empties the FIFO.
- `in_valid` in 1: upstream holds a valid shift op.
- `in_ready` out 1: the unit can accept the op this cycle.
- `in_funct3` in 3: 3'b001 = SLL, 3'b101 = SRL/SRA.
- `in_funct7_5` in 1: instruction bit 30; selects SRA when funct3 = 101.
- `in_src1` in WIDTH: value to shift.
- `in_src2` in WIDTH: shift amount source; only bits [SHW-1:0] are used.
- `in_rd` in 5: destination register tag, passed through.
- `out_valid` out 1: the FIFO head is valid.
- `out_ready` in 1: downstream consumes the head.
- `out_result` out WIDTH: shifted value.
- `out_rd` out 5: tag of the head entry.
- `out_illegal` out 1: the head entry had an illegal encoding.

## Operation
- Fire conditions:
  - Accept: `in_valid && in_ready`.
  - Pop: `out_valid && out_ready`.
- Decode:
  - `is_left = (funct3 == 001)`.
  - `is_logical = !funct7_5`.
  - Shift amount = `in_src2[SHW-1:0]`, zero-extended to WIDTH before driving `ins`.
- Legality:
  - funct3 ∉ {001, 101} is illegal.
  - funct3 = 001 with funct7_5 = 1 is illegal.
  - An illegal entry is still enqueued, with result forced to 0 and `illegal` = 1. It is never dropped.
- SRA is a true arithmetic shift: the sign is replicated from `in_src1[WIDTH-1]`. The shifter input must be treated as signed for `>>>`.
- FIFO:
  - Depth 2, entries {result, rd, illegal}, with a 2-bit count (0..2).
  - Read/write pointers are 1 bit each and wrap.
- Handshake rules:
  - `in_ready = (count != 2)`. It is a registered-state function only and does not depend on `out_ready`.
  - Accept and pop in the same cycle: count is unchanged and both pointers advance.
  - At count = 2, `in_ready` = 0 even if `out_ready` = 1 that cycle. There is no full-bypass.
  - `out_valid = (count != 0)`.
  - `out_result`, `out_rd` and `out_illegal` are the head entry. While `out_valid` = 1 and `out_ready` = 0, they hold stable.
- Flush:
  - Count and pointers go to 0 on the next edge.
  - Any accept in the flush cycle is discarded.
  - `in_ready` is not gated by flush.
- Upstream contract: inputs must hold stable while `in_valid && !in_ready`. The bench checks this with an assertion.

## Timing
- Latency: accept at edge N, so `out_valid` = 1 with the result after edge N. Minimum one cycle, no combinational in→out path.
- Throughput: one op per cycle while downstream keeps `out_ready` high.
- Reset (async assert, sync-safe deassert): count = 0, pointers = 0, `out_valid` = 0, `in_ready` = 1. `out_result`, `out_rd` and `out_illegal` read 0 because storage is cleared too.
- Reset mid-operation: all buffered entries are lost immediately, with no pending output.
- Critical path: decode → `Shift` → FIFO write-data mux. It must meet one cycle at WIDTH = 32.

## Structure
- Shared package `exu_pkg`:
  - `FUNCT3_SLL = 3'b001`.
  - `FUNCT3_SRX = 3'b101`.
  - Typedef for the FIFO entry struct {result, rd, illegal}.
- One sub-module: the existing `Shift` (WIDTH passed through), instantiated once.
- FIFO is inline: two entry registers plus count and pointers. It does not need its own module.

## Test plan
- SLL `src1 = 0x00000001`, `src2 = 31` → `out_result = 0x80000000`, `out_rd` echoed, `out_illegal` = 0, one cycle after accept.
- SRA vs SRL on `src1 = 0x80000000`, `src2 = 4`:
  - SRA (`funct7_5` = 1) → `0xF8000000`.
  - SRL → `0x08000000`.
- Amount masking: `src2 = 0x00000025`, SLL of `0x00000003` → shift by 5 → `0x00000060`.
- Backpressure: `out_ready` = 0 while issuing 3 back-to-back ops.
  - Two are accepted, then `in_ready` = 0.
  - Head holds stable.
  - Release `out_ready` → results drain in order with no loss or duplication.
- Illegal encodings: funct3 = 000, and funct3 = 001 with funct7_5 = 1 → each enqueued with result 0 and `out_illegal` = 1, order preserved.
- Flush and async reset with 2 entries buffered → `out_valid` = 0 next cycle (immediately for `rst`), `in_ready` = 1, and a new op then completes normally.

Source files
------------

// File: rtl/exu_shift_unit_pkg.sv
// Shared execute-stage definitions for the shift unit: funct3 encodings,
// the result-FIFO entry type and the legality decode.
package exu_pkg;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SRX = 3'b101;

  // Entry result field is sized for the widest supported datapath.
  localparam int EXU_MAX_W = 64;

  typedef struct packed {
    logic [EXU_MAX_W-1:0] result;
    logic [4:0]           rd;
    logic                 illegal;
  } exu_shift_entry_t;

  function automatic logic shift_legal(input logic [2:0] funct3, input logic funct7_5);
    return (funct3 == FUNCT3_SRX) || ((funct3 == FUNCT3_SLL) && !funct7_5);
  endfunction

endpackage

// File: rtl/exu_shift_unit_shift.sv
// Combinational barrel shifter: SLL, SRL, or SRA with sign replication from din MSB.
module Shift #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] ins,
  input  logic             is_left,
  input  logic             is_logical,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    if (is_left)         dout = din << ins;
    else if (is_logical) dout = din >> ins;
    else                 dout = $signed(din) >>> ins;
  end

endmodule

// File: rtl/exu_shift_unit.sv
// Execute-stage shift wrapper: decodes RV32I shift ops, drives the Shift
// datapath and buffers results in a 2-entry FIFO for writeback backpressure.
module exu_shift_unit
  import exu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_illegal
);

  logic             is_left, is_logical, legal;
  logic [WIDTH-1:0] shamt, sh_out;
  logic             push, pop;

  exu_shift_entry_t       wr_entry, head;
  exu_shift_entry_t [1:0] mem_q;
  logic                   wptr_q, rptr_q;
  logic [1:0]             cnt_q, cnt_d;

  assign is_left    = (in_funct3 == FUNCT3_SLL);
  assign is_logical = !in_funct7_5;
  assign legal      = shift_legal(in_funct3, in_funct7_5);
  assign shamt      = WIDTH'(in_src2[SHW-1:0]);

  logic unused_src2_hi;
  assign unused_src2_hi = ^in_src2[WIDTH-1:SHW];

  Shift #(.WIDTH(WIDTH)) u_shift (
    .din        (in_src1),
    .ins        (shamt),
    .is_left    (is_left),
    .is_logical (is_logical),
    .dout       (sh_out)
  );

  always_comb begin
    wr_entry         = '0;
    wr_entry.result  = legal ? EXU_MAX_W'(sh_out) : '0;
    wr_entry.rd      = in_rd;
    wr_entry.illegal = !legal;
  end

  // in_ready depends on registered count only; no bypass when full.
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    cnt_d = cnt_q;
    if (flush)              cnt_d = '0;
    else if (push && !pop)  cnt_d = cnt_q + 2'd1;
    else if (pop && !push)  cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      mem_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        wptr_q <= 1'b0;
        rptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wptr_q] <= wr_entry;
          wptr_q        <= ~wptr_q;
        end
        if (pop) rptr_q <= ~rptr_q;
      end
    end
  end

  assign head        = mem_q[rptr_q];
  assign out_result  = head.result[WIDTH-1:0];
  assign out_rd      = head.rd;
  assign out_illegal = head.illegal;

  if (WIDTH < EXU_MAX_W) begin : g_result_hi
    logic unused_result_hi;
    assign unused_result_hi = ^head.result[EXU_MAX_W-1:WIDTH];
  end

endmodule

// File: tb/tb_exu_shift_unit.sv
// Scenario bench for exu_shift_unit with a queue scoreboard on the output port.
module tb_exu_shift_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_funct7_5;
  logic [2:0]  in_funct3;
  logic [31:0] in_src1, in_src2, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        out_valid, out_ready, out_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  exu_shift_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  // Upstream contract: a stalled op must not change until accepted or withdrawn.
  logic        hold_q = 1'b0;
  logic [72:0] hold_data_q;
  always @(posedge clk) begin
    if (!rst && hold_q && in_valid)
      assert ({in_funct3, in_funct7_5, in_src1, in_src2, in_rd} == hold_data_q)
        else $error("upstream op changed while stalled");
    hold_q      <= in_valid && !in_ready && !rst;
    hold_data_q <= {in_funct3, in_funct7_5, in_src1, in_src2, in_rd};
  end

  function automatic exp_t model(input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    int   sh;
    sh    = int'(b[4:0]);
    e.rd  = rd;
    e.ill = 1'b1;
    e.res = 32'h0;
    if (f3 == 3'b001 && !f7) begin
      e.ill = 1'b0;
      e.res = a << sh;
    end else if (f3 == 3'b101) begin
      e.ill = 1'b0;
      e.res = a >> sh;
      if (f7 && a[31])
        for (int i = 0; i < sh; i++) e.res[31-i] = 1'b1;
    end
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || flush) sb.delete();
      else begin
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow got %h/%0d/%b want nothing", out_result, out_rd, out_illegal);
          end else begin
            e = sb.pop_front();
            if ({out_result, out_rd, out_illegal} !== {e.res, e.rd, e.ill}) begin
              errors++;
              $display("FAIL sb_pop got %h/%0d/%b want %h/%0d/%b",
                       out_result, out_rd, out_illegal, e.res, e.rd, e.ill);
            end
          end
        end
        if (in_valid && in_ready)
          sb.push_back(model(in_funct3, in_funct7_5, in_src1, in_src2, in_rd));
      end
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic f7, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1; in_funct3 = f3; in_funct7_5 = f7; in_src1 = a; in_src2 = b; in_rd = rd;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [2:0] f3, input logic f7, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd);
    int n = 0;
    drive(f3, f7, a, b, rd);
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_result, out_rd, out_illegal} !== {1'b0, 1'b1, 32'h0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got v=%b rdy=%b res=%h rd=%0d ill=%b want v=0 rdy=1 res=0 rd=0 ill=0",
               out_valid, in_ready, out_result, out_rd, out_illegal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sll();
    out_ready = 1'b1;
    send(3'b001, 1'b0, 32'h1, 32'd31, 5'd7);
    @(negedge clk);
    checks++;
    if ({out_valid, out_result, out_rd, out_illegal} !== {1'b1, 32'h80000000, 5'd7, 1'b0}) begin
      errors++;
      $display("FAIL sll_latency got v=%b res=%h rd=%0d ill=%b want v=1 res=80000000 rd=7 ill=0",
               out_valid, out_result, out_rd, out_illegal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sra_srl();
    out_ready = 1'b1;
    send(3'b101, 1'b1, 32'h80000000, 32'd4, 5'd3);
    @(negedge clk);
    checks++;
    if (out_result !== 32'hF8000000) begin
      errors++; $display("FAIL sra got %h want f8000000", out_result);
    end
    @(posedge clk); #1;
    send(3'b101, 1'b0, 32'h80000000, 32'd4, 5'd4);
    @(negedge clk);
    checks++;
    if (out_result !== 32'h08000000) begin
      errors++; $display("FAIL srl got %h want 08000000", out_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_amount_mask();
    out_ready = 1'b1;
    send(3'b001, 1'b0, 32'h3, 32'h25, 5'd9);
    @(negedge clk);
    checks++;
    if (out_result !== 32'h60) begin
      errors++; $display("FAIL amount_mask got %h want 00000060", out_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    drive(3'b001, 1'b0, 32'h1, 32'd1, 5'd1);
    @(posedge clk); #1 drive(3'b101, 1'b0, 32'h100, 32'd4, 5'd2);
    @(posedge clk); #1 drive(3'b101, 1'b1, 32'hFFFF0000, 32'd8, 5'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_result, out_rd} !== {1'b0, 1'b1, 32'h2, 5'd1}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b res=%h rd=%0d want rdy=0 v=1 res=00000002 rd=1",
                 k, in_ready, out_valid, out_result, out_rd);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 10) begin @(negedge clk); n++; end
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_valid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got v=%b pending=%0d want v=0 pending=0", out_valid, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    send(3'b000, 1'b0, 32'h1234, 32'd3, 5'd10);
    send(3'b001, 1'b1, 32'h55, 32'd2, 5'd11);
    @(negedge clk);
    checks++;
    if ({out_valid, out_result, out_rd, out_illegal} !== {1'b1, 32'h0, 5'd10, 1'b1}) begin
      errors++;
      $display("FAIL illegal_f3 got v=%b res=%h rd=%0d ill=%b want v=1 res=0 rd=10 ill=1",
               out_valid, out_result, out_rd, out_illegal);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_result, out_rd, out_illegal} !== {1'b1, 32'h0, 5'd11, 1'b1}) begin
      errors++;
      $display("FAIL illegal_sll_f7 got v=%b res=%h rd=%0d ill=%b want v=1 res=0 rd=11 ill=1",
               out_valid, out_result, out_rd, out_illegal);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(3'b001, 1'b0, 32'hA, 32'd1, 5'd12);
    send(3'b001, 1'b0, 32'hB, 32'd1, 5'd13);
    drive(3'b001, 1'b0, 32'hC, 32'd1, 5'd14);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_full_ready got %b want 0", in_ready);
    end
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_empty got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    // An accept coinciding with flush must be discarded.
    @(posedge clk); #1 drive(3'b001, 1'b0, 32'hD, 32'd1, 5'd15); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_discard got v=%b want 0", out_valid);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(3'b101, 1'b0, 32'hF0, 32'd4, 5'd16);
    @(negedge clk);
    checks++;
    if ({out_valid, out_result, out_rd} !== {1'b1, 32'hF, 5'd16}) begin
      errors++;
      $display("FAIL flush_recover got v=%b res=%h rd=%0d want v=1 res=0000000f rd=16",
               out_valid, out_result, out_rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(3'b001, 1'b0, 32'h7, 32'd2, 5'd20);
    send(3'b001, 1'b0, 32'h8, 32'd2, 5'd21);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, out_result} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_async got v=%b rdy=%b res=%h want v=0 rdy=1 res=0", out_valid, in_ready, out_result);
    end
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    send(3'b101, 1'b1, 32'h80000001, 32'd31, 5'd22);
    @(negedge clk);
    checks++;
    if ({out_valid, out_result, out_rd} !== {1'b1, 32'hFFFFFFFF, 5'd22}) begin
      errors++;
      $display("FAIL reset_recover got v=%b res=%h rd=%0d want v=1 res=ffffffff rd=22",
               out_valid, out_result, out_rd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'b0; in_funct7_5 = 1'b0; in_src1 = '0; in_src2 = '0; in_rd = '0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_sll();
    test_sra_srl();
    test_amount_mask();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
